// File: rtl/mod_mem_access_unit.sv
// MEM-stage memory access sequencer: one Avalon-MM read or write per request, load extension, store lane shift.
// Optional feature: define MISALIGNED_TRAP_EN to complete misaligned half/word requests without a bus cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BYTEENABLE_WIDTH
`define BYTEENABLE_WIDTH 4
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

module mod_mem_access_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    input  logic                         req_is_store_i,
    input  logic [`FUNCT3_WIDTH-1:0]     funct3_i,
    input  logic [`XLEN-1:0]             addr_aligned_i,
    input  logic [1:0]                   byte_offset_i,
    input  logic [`BYTEENABLE_WIDTH-1:0] byteenable_i,
    input  logic [`XLEN-1:0]             store_data_i,
    output logic                         stall_o,
    output logic                         done_o,
    output logic [`XLEN-1:0]             load_data_o,
    output logic                         bus_error_o,
    output logic                         misaligned_o,
    output logic [`XLEN-1:0]             avm_address_o,
    output logic                         avm_read_o,
    output logic                         avm_write_o,
    output logic [`XLEN-1:0]             avm_writedata_o,
    output logic [`BYTEENABLE_WIDTH-1:0] avm_byteenable_o,
    input  logic                         avm_waitrequest_i,
    input  logic [`XLEN-1:0]             avm_readdata_i,
    input  logic                         avm_readdatavalid_i
);
    localparam int XL  = `XLEN;
    localparam int BEW = `BYTEENABLE_WIDTH;
    localparam int F3W = `FUNCT3_WIDTH;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    localparam logic [F3W-1:0] F3_B  = F3W'(0);
    localparam logic [F3W-1:0] F3_H  = F3W'(1);
    localparam logic [F3W-1:0] F3_W  = F3W'(2);
    localparam logic [F3W-1:0] F3_BU = F3W'(4);
    localparam logic [F3W-1:0] F3_HU = F3W'(5);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP, S_DONE} state_e;

    state_e         state_q, state_d;
    logic [XL-1:0]  addr_q, addr_d;
    logic [XL-1:0]  wdata_q, wdata_d;
    logic [XL-1:0]  ldata_q, ldata_d;
    logic [BEW-1:0] be_q, be_d;
    logic [F3W-1:0] funct3_q, funct3_d;
    logic [1:0]     offset_q, offset_d;
    logic           store_q, store_d;
    logic           err_q, err_d;
    logic           mis_q, mis_d;
    logic [7:0]     wait_q, wait_d;

    // Every byte-lane shift of the store operand and of the read word, selected by offset below.
    logic [XL-1:0] st_lane [4];
    logic [XL-1:0] rd_lane [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_lane[gi] = store_data_i << (8 * gi);
            assign rd_lane[gi] = avm_readdata_i >> (8 * gi);
        end
    endgenerate

    logic [XL-1:0] store_shifted;
    assign store_shifted = ((funct3_i == F3_B) || (funct3_i == F3_H)) ? st_lane[byte_offset_i]
                                                                      : store_data_i;

    logic req_misaligned;
`ifdef MISALIGNED_TRAP_EN
    assign req_misaligned = ((funct3_i == F3_H || (!req_is_store_i && funct3_i == F3_HU))
                             && byte_offset_i == 2'd3)
                          || (funct3_i == F3_W && byte_offset_i != 2'd0);
`else
    assign req_misaligned = 1'b0;
`endif

    logic [XL-1:0] rd_word;
    logic [XL-1:0] load_ext;
    assign rd_word = rd_lane[offset_q];

    always_comb begin
        load_ext = '0;
        case (funct3_q)
            F3_B:    load_ext = {{(XL-8){rd_word[7]}}, rd_word[7:0]};
            F3_BU:   load_ext = {{(XL-8){1'b0}}, rd_word[7:0]};
            F3_H:    load_ext = {{(XL-16){rd_word[15]}}, rd_word[15:0]};
            F3_HU:   load_ext = {{(XL-16){1'b0}}, rd_word[15:0]};
            F3_W:    load_ext = rd_word;
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            ldata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
            offset_q <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ldata_q  <= ldata_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            store_q  <= store_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ldata_d  = ldata_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        store_d  = store_q;
        err_d    = err_q;
        mis_d    = mis_q;
        wait_d   = wait_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = addr_aligned_i;
                    wdata_d  = store_shifted;
                    be_d     = byteenable_i;
                    funct3_d = funct3_i;
                    offset_d = byte_offset_i;
                    store_d  = req_is_store_i;
                    ldata_d  = '0;
                    err_d    = 1'b0;
                    mis_d    = req_misaligned;
                    wait_d   = '0;
                    state_d  = req_misaligned ? S_DONE : S_CMD;
                end
            end
            S_CMD: begin
                if (!avm_waitrequest_i) begin
                    wait_d  = '0;
                    state_d = store_q ? S_DONE : S_RESP;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_RESP: begin
                // A response on the last permitted cycle still wins over the timeout.
                if (avm_readdatavalid_i) begin
                    ldata_d = load_ext;
                    state_d = S_DONE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic in_cmd;
    assign in_cmd           = (state_q == S_CMD);
    assign done_o           = (state_q == S_DONE);
    assign stall_o          = (state_q == S_IDLE && req_valid_i) || in_cmd || (state_q == S_RESP);
    assign load_data_o      = done_o ? ldata_q : '0;
    assign bus_error_o      = done_o & err_q;
    assign misaligned_o     = done_o & mis_q;
    assign avm_read_o       = in_cmd & ~store_q;
    assign avm_write_o      = in_cmd & store_q;
    assign avm_address_o    = in_cmd ? addr_q : '0;
    assign avm_writedata_o  = in_cmd ? wdata_q : '0;
    assign avm_byteenable_o = in_cmd ? be_q : '0;
endmodule

// File: doc/mod_mem_access_unit.md
# mod_mem_access_unit

Memory access sequencer in the MEM stage, directly downstream of the byte-enable/alignment generator. It takes the aligned word address and byte enables produced there, runs one Avalon-MM-style read or write on the data bus, and stalls the pipeline until the transfer finishes. Loads return byte/half/word data that is extracted, sign- or zero-extended and registered. Stores have their data shifted onto the byte lanes selected by the enables.

## Interface
Parameters:
- MAX_WAIT, default 255: cycles allowed in any single wait state before the bus-timeout error; 8-bit counter; range 1..255.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  pipeline presents a memory op; held stable with all request fields until done_o.
- req_is_store_i  in  1  1 = store, 0 = load.
- funct3_i  in  `FUNCT3_WIDTH  load/store width code.
- addr_aligned_i  in  `XLEN  word-aligned address, low 2 bits zero.
- byte_offset_i  in  2  unaligned address bits [1:0].
- byteenable_i  in  `BYTEENABLE_WIDTH  lane enables from the alignment stage.
- store_data_i  in  `XLEN  raw rs2 value, unshifted.
- stall_o  out  1  hold the pipeline.
- done_o  out  1  one-cycle completion pulse.
- load_data_o  out  `XLEN  extended load result; valid while done_o=1.
- bus_error_o  out  1  timeout flag; valid while done_o=1.
- misaligned_o  out  1  misalignment flag; valid while done_o=1.
- avm_address_o  out  `XLEN
- avm_read_o  out  1
- avm_write_o  out  1
- avm_writedata_o  out  `XLEN
- avm_byteenable_o  out  `BYTEENABLE_WIDTH
- avm_waitrequest_i  in  1
- avm_readdata_i  in  `XLEN
- avm_readdatavalid_i  in  1

## Operation
- States: IDLE, CMD, RESP, DONE.
- IDLE, req_valid_i=1: register address, enables, funct3, offset, store flag, and shifted store data; go to CMD.
- CMD: drive avm_read_o or avm_write_o plus address, enables and writedata from registers. All stay constant while avm_waitrequest_i=1.
  - Command accepted (waitrequest=0), write: go to DONE.
  - Command accepted, read: go to RESP.
- RESP: wait for avm_readdatavalid_i. On the valid cycle, capture the extracted data and go to DONE.
- DONE: done_o=1 for exactly one cycle, then return to IDLE.
- Store lane shift: writedata = store_data_i << (8*byte_offset_i) for SB/SH; SW is unshifted.
- Load extraction: w = readdata >> (8*offset).
  - LB: sign-extend w[7:0]. LBU: zero-extend w[7:0].
  - LH: sign-extend w[15:0]. LHU: zero-extend w[15:0].
  - LW: w.
  - Other funct3: 0.
- Stores complete with load_data_o=0.
- Timeout: an 8-bit wait counter clears on entry to CMD and on entry to RESP, and increments each cycle spent in that state. Reaching MAX_WAIT goes to DONE with bus_error_o=1 and load_data_o=0. avm_read_o and avm_write_o drop the same cycle.
- avm_readdatavalid_i is ignored outside RESP: stray responses, or responses to a command abandoned by reset or timeout.

## Timing
- Reset values: state IDLE; every output 0.
- Reset mid-transfer: state IDLE on the next edge. avm_read_o and avm_write_o are low the following cycle. No done_o pulse is produced.
- stall_o = (IDLE and req_valid_i) or CMD or RESP. It is low in DONE, so the pipeline advances on the DONE edge.
- Minimum write latency: request seen at cycle 0; CMD at cycle 1 with waitrequest=0; done_o at cycle 2.
- Minimum read latency: CMD at cycle 1; readdatavalid at cycle 2; done_o and load_data_o at cycle 3.
- readdatavalid in the CMD accept cycle is ignored. Responses arrive one or more cycles after acceptance.
- req_valid_i during DONE belongs to the next instruction and is sampled in IDLE on the following cycle. There is one idle cycle between back-to-back transfers.
- One outstanding transfer at most.

## Configuration
- MISALIGNED_TRAP_EN defined:
  - In IDLE, these are misaligned: LH/LHU/SH with offset 3, and LW/SW with offset ≠ 0.
  - A misaligned request issues no bus cycle. It goes IDLE→DONE, with done_o at cycle 1, misaligned_o=1 and load_data_o=0.
- MISALIGNED_TRAP_EN undefined: misaligned_o is tied 0 and every request is issued as given.

## Test plan
- SW to 0x100 of 0xDEADBEEF, offset 0, waitrequest low: avm_write_o at cycle 1 with byteenable 4'b1111; done_o at cycle 2; stall_o high for cycles 0–1.
- SB 0x000000A5 at offset 2, waitrequest high for 3 cycles: writedata 0x00A50000 and byteenable 4'b0100 held constant; done_o 1 cycle after waitrequest falls.
- Load with readdata 0x80F0_7F81: LB offset 0 → 0xFFFFFF81; LBU offset 3 → 0x00000080; LH offset 2 → 0xFFFF80F0; LW → 0x80F07F81.
- Read with MAX_WAIT=4 and readdatavalid never asserted: done_o with bus_error_o=1 and load_data_o=0 after 4 RESP cycles. A late readdatavalid in IDLE has no effect.
- rst_i asserted during RESP: outputs are 0 on the next cycle; no done_o; a later readdatavalid is ignored.
- With MISALIGNED_TRAP_EN, LW at offset 1: no avm_read_o; done_o at cycle 1 with misaligned_o=1.
